// File: rtl/umii_link_fault_pkg.sv
// Shared types and constants for the uMII RS link-fault controller.
// Includes the single-column fault-sequence classifier.
package umii_link_fault_pkg;

  typedef enum logic [1:0] {
    LF_OK     = 2'b00,
    LF_LOCAL  = 2'b01,
    LF_REMOTE = 2'b10
  } link_fault_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    COUNT = 2'd1,
    FAULT = 2'd2
  } fsm_t;

  localparam logic [7:0] SEQ_CHAR = 8'h9C;
  localparam logic [7:0] LF_CODE  = 8'h01;
  localparam logic [7:0] RF_CODE  = 8'h02;

  localparam int unsigned COL_BITS  = 32;
  localparam int unsigned COL_FLAGS = 4;

  // LF_OK means the column is not a fault sequence.
  function automatic link_fault_t classify_col(input logic [COL_BITS-1:0]  d,
                                               input logic [COL_FLAGS-1:0] c);
    link_fault_t t;
    t = LF_OK;
    if (c == 4'b0001 && d[7:0] == SEQ_CHAR && d[23:8] == 16'h0000) begin
      if (d[31:24] == LF_CODE) begin
        t = LF_LOCAL;
      end else if (d[31:24] == RF_CODE) begin
        t = LF_REMOTE;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/umii_seq_detect.sv
// Stage 1: classify every column of the uMII word and register the
// lowest-index fault sequence, so at most one sequence counts per word.
module umii_seq_detect
  import umii_link_fault_pkg::*;
#(
  parameter int unsigned MII_DATA_WIDTH = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MII_DATA_WIDTH-1:0]   rxd,
  input  logic [MII_DATA_WIDTH/8-1:0] rxc,
  output logic                        fault_vld,
  output link_fault_t                 fault_type
);

  localparam int unsigned COLS = MII_DATA_WIDTH / COL_BITS;

  logic        hit;
  link_fault_t hit_type;
  link_fault_t col_type;

  // Priority encoder: first fault column from the LSB side wins.
  always_comb begin
    hit      = 1'b0;
    hit_type = LF_LOCAL;
    col_type = LF_OK;
    for (int unsigned c = 0; c < COLS; c++) begin
      col_type = classify_col(rxd[COL_BITS*c +: COL_BITS], rxc[COL_FLAGS*c +: COL_FLAGS]);
      if (!hit && col_type != LF_OK) begin
        hit      = 1'b1;
        hit_type = col_type;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_vld  <= 1'b0;
      fault_type <= LF_LOCAL;
    end else begin
      fault_vld  <= hit;
      fault_type <= hit_type;
    end
  end

endmodule

// File: rtl/umii_link_fault_ctrl.sv
// RS link-fault state machine over a wide uMII RX word: tracks LF/RF
// sequences, drives TX fault signalling, gates umii_dec and counts faults.
module umii_link_fault_ctrl
  import umii_link_fault_pkg::*;
#(
  parameter int unsigned MII_DATA_WIDTH = 512,
  parameter int unsigned COL_THRESH     = 128,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [MII_DATA_WIDTH-1:0]   MII_RXD,
  input  logic [MII_DATA_WIDTH/8-1:0] MII_RXC,
  input  logic                        CTRL_EN,
  input  logic                        FAULT_CNT_CLR,
  output logic [1:0]                  LINK_STATUS,
  output logic                        DEC_ENABLE,
  output logic                        TX_RF_REQ,
  output logic                        TX_IDLE_REQ,
  output logic [CNT_WIDTH-1:0]        FAULT_EVENT_CNT
);

  localparam int unsigned COLS   = MII_DATA_WIDTH / COL_BITS;
  localparam int unsigned COL_W  = $clog2(COL_THRESH + COLS);
  localparam int unsigned COL_SW = COL_W + 1;

  logic        fault_vld;
  link_fault_t fault_type;

  fsm_t              state, state_nxt;
  link_fault_t       seq_type, type_nxt;
  logic [1:0]        seq_cnt, cnt_nxt;
  logic [COL_W-1:0]  col_cnt, col_nxt;
  link_fault_t       link_fault, link_nxt;
  logic              fault_entry;
  logic [COL_SW-1:0] col_sum;
  logic              col_hit;
  logic [COL_W-1:0]  col_sat;
  logic [CNT_WIDTH-1:0] evt_nxt;

  umii_seq_detect #(
    .MII_DATA_WIDTH (MII_DATA_WIDTH)
  ) u_seq_detect (
    .clk        (CLK),
    .rst        (RESET),
    .rxd        (MII_RXD),
    .rxc        (MII_RXC),
    .fault_vld  (fault_vld),
    .fault_type (fault_type)
  );

  // Fault-free column accumulation, saturating at the threshold.
  always_comb begin
    col_sum = COL_SW'(col_cnt) + COL_SW'(COLS);
    col_hit = (col_sum >= COL_SW'(COL_THRESH));
    col_sat = col_hit ? COL_W'(COL_THRESH) : COL_W'(col_sum);
  end

  always_comb begin
    state_nxt   = state;
    type_nxt    = seq_type;
    cnt_nxt     = seq_cnt;
    col_nxt     = col_cnt;
    link_nxt    = link_fault;
    fault_entry = 1'b0;
    case (state)
      INIT: begin
        if (fault_vld) begin
          state_nxt = COUNT;
          type_nxt  = fault_type;
          cnt_nxt   = 2'd1;
          col_nxt   = '0;
        end
      end
      COUNT: begin
        if (fault_vld) begin
          col_nxt = '0;
          if (fault_type == seq_type) begin
            if (seq_cnt == 2'd3) begin
              state_nxt   = FAULT;
              link_nxt    = seq_type;
              fault_entry = 1'b1;
            end else begin
              cnt_nxt = seq_cnt + 2'd1;
            end
          end else begin
            type_nxt = fault_type;
            cnt_nxt  = 2'd1;
          end
        end else begin
          col_nxt = col_sat;
          if (col_hit) begin
            state_nxt = INIT;
            link_nxt  = LF_OK;
          end
        end
      end
      FAULT: begin
        if (fault_vld) begin
          col_nxt = '0;
          if (fault_type != seq_type) begin
            state_nxt = COUNT;
            type_nxt  = fault_type;
            cnt_nxt   = 2'd1;
          end
        end else begin
          col_nxt = col_sat;
          if (col_hit) begin
            state_nxt = INIT;
            link_nxt  = LF_OK;
          end
        end
      end
      default: begin
        state_nxt = INIT;
        link_nxt  = LF_OK;
      end
    endcase
  end

  // A clear coinciding with a FAULT entry leaves that entry counted.
  always_comb begin
    evt_nxt = FAULT_EVENT_CNT;
    if (FAULT_CNT_CLR) begin
      evt_nxt = fault_entry ? CNT_WIDTH'(1) : '0;
    end else if (fault_entry) begin
      evt_nxt = FAULT_EVENT_CNT + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= INIT;
      seq_type        <= LF_LOCAL;
      seq_cnt         <= 2'd0;
      col_cnt         <= '0;
      link_fault      <= LF_OK;
      DEC_ENABLE      <= 1'b0;
      TX_RF_REQ       <= 1'b0;
      TX_IDLE_REQ     <= 1'b0;
      FAULT_EVENT_CNT <= '0;
    end else begin
      state           <= state_nxt;
      seq_type        <= type_nxt;
      seq_cnt         <= cnt_nxt;
      col_cnt         <= col_nxt;
      link_fault      <= link_nxt;
      DEC_ENABLE      <= CTRL_EN && (link_nxt == LF_OK);
      TX_RF_REQ       <= (link_nxt == LF_LOCAL);
      TX_IDLE_REQ     <= (link_nxt == LF_REMOTE);
      FAULT_EVENT_CNT <= evt_nxt;
    end
  end

  assign LINK_STATUS = link_fault;

endmodule
